// File: rtl/cam_stream_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cam_stream_gen : OV7670-style RGB565 test-pattern stream source  (rev 1.0) |
// +----------------------------------------------------------------------------+
module cam_stream_gen #(
  parameter int H_ACTIVE  = 160,
  parameter int V_ACTIVE  = 120,
  parameter int H_BLANK   = 144,
  parameter int VSYNC_LEN = 3,
  parameter int V_BACK    = 17,
  parameter int V_FRONT   = 10
) (
  input  logic        CAM_PCLK,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb565,
  output logic        CAM_VSYNC,
  output logic        CAM_HREF,
  output logic [7:0]  CAM_px_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int         LINE_LEN    = 2*H_ACTIVE + H_BLANK;
  localparam int         BAR_W       = H_ACTIVE/8;
  localparam logic [9:0] LINE_LAST   = 10'(LINE_LEN - 1);
  localparam logic [9:0] BYTE_LAST   = 10'(2*H_ACTIVE - 1);
  localparam logic [9:0] HBLANK_LAST = 10'(H_BLANK - 1);
  localparam logic [5:0] VSYNC_LAST  = 6'(VSYNC_LEN - 1);
  localparam logic [5:0] VBACK_LAST  = 6'(V_BACK - 1);
  localparam logic [5:0] VFRONT_LAST = 6'(V_FRONT - 1);
  localparam logic [8:0] Y_END       = 9'(V_ACTIVE);
  localparam logic [6:0] BAR_LAST    = 7'(BAR_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_HBLANK, S_VFRONT
  } state_t;

  state_t      r_state;
  logic [9:0]  r_cyc;
  logic [9:0]  r_bcnt;
  logic [8:0]  r_y;
  logic [5:0]  r_vline;
  logic [7:0]  r_px_x;
  logic [2:0]  r_bar;
  logic [6:0]  r_bar_pos;
  logic [1:0]  r_pat;
  logic [15:0] r_solid;
  logic [7:0]  r_lo_byte;
  logic [15:0] w_bar_rgb;
  logic [15:0] w_pixel;
  logic        w_line_end;
  logic        w_emit_hi;

  always_comb begin
    case (r_bar)
      3'd0:    w_bar_rgb = 16'hFFFF;
      3'd1:    w_bar_rgb = 16'hFFE0;
      3'd2:    w_bar_rgb = 16'h07FF;
      3'd3:    w_bar_rgb = 16'h07E0;
      3'd4:    w_bar_rgb = 16'hF81F;
      3'd5:    w_bar_rgb = 16'hF800;
      3'd6:    w_bar_rgb = 16'h001F;
      default: w_bar_rgb = 16'h0000;
    endcase
  end

  // r_px_x / r_bar / r_y always describe the pixel whose high byte goes out next.
  always_comb begin
    case (r_pat)
      2'd0:    w_pixel = w_bar_rgb;
      2'd1:    w_pixel = {r_px_x[7:3], r_px_x[7:2], r_px_x[7:3]};
      2'd2:    w_pixel = r_solid;
      default: w_pixel = (r_px_x[3] ^ r_y[3]) ? 16'hFFFF : 16'h0000;
    endcase
  end

  assign w_line_end = (r_cyc == LINE_LAST);

  always_comb begin
    w_emit_hi = 1'b0;
    case (r_state)
      S_VBACK:  w_emit_hi = w_line_end && (r_vline == VBACK_LAST);
      S_ACTIVE: w_emit_hi = (r_bcnt != BYTE_LAST) && r_bcnt[0];
      S_HBLANK: w_emit_hi = (r_cyc == HBLANK_LAST) && (r_y < Y_END);
      default:  w_emit_hi = 1'b0;
    endcase
  end

  always_ff @(posedge CAM_PCLK or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cyc       <= '0;
      r_bcnt      <= '0;
      r_y         <= '0;
      r_vline     <= '0;
      r_px_x      <= '0;
      r_bar       <= '0;
      r_bar_pos   <= '0;
      r_pat       <= '0;
      r_solid     <= '0;
      r_lo_byte   <= '0;
      CAM_VSYNC   <= 1'b0;
      CAM_HREF    <= 1'b0;
      CAM_px_data <= '0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state   <= S_VSYNC;
            CAM_VSYNC <= 1'b1;
            r_pat     <= pattern_sel;
            r_solid   <= solid_rgb565;
            r_cyc     <= '0;
            r_vline   <= '0;
            r_y       <= '0;
          end
        end
        S_VSYNC: begin
          r_cyc <= w_line_end ? 10'd0 : r_cyc + 10'd1;
          if (w_line_end) begin
            if (r_vline == VSYNC_LAST) begin
              r_vline   <= '0;
              r_state   <= S_VBACK;
              CAM_VSYNC <= 1'b0;
            end else begin
              r_vline <= r_vline + 6'd1;
            end
          end
        end
        S_VBACK: begin
          r_cyc <= w_line_end ? 10'd0 : r_cyc + 10'd1;
          if (w_line_end) begin
            if (r_vline == VBACK_LAST) begin
              r_vline  <= '0;
              r_state  <= S_ACTIVE;
              CAM_HREF <= 1'b1;
              r_bcnt   <= '0;
            end else begin
              r_vline <= r_vline + 6'd1;
            end
          end
        end
        S_ACTIVE: begin
          if (r_bcnt == BYTE_LAST) begin
            r_state     <= S_HBLANK;
            CAM_HREF    <= 1'b0;
            CAM_px_data <= '0;
            r_cyc       <= '0;
            r_y         <= r_y + 9'd1;
            r_px_x      <= '0;
            r_bar       <= '0;
            r_bar_pos   <= '0;
          end else begin
            r_bcnt <= r_bcnt + 10'd1;
            if (!r_bcnt[0]) CAM_px_data <= r_lo_byte;
          end
        end
        S_HBLANK: begin
          if (r_cyc == HBLANK_LAST) begin
            r_cyc <= '0;
            if (r_y < Y_END) begin
              r_state  <= S_ACTIVE;
              CAM_HREF <= 1'b1;
              r_bcnt   <= '0;
            end else begin
              r_state <= S_VFRONT;
              r_vline <= '0;
            end
          end else begin
            r_cyc <= r_cyc + 10'd1;
          end
        end
        S_VFRONT: begin
          r_cyc <= w_line_end ? 10'd0 : r_cyc + 10'd1;
          if (w_line_end) begin
            if (r_vline == VFRONT_LAST) begin
              r_vline    <= '0;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
              if (enable) begin
                r_state   <= S_VSYNC;
                CAM_VSYNC <= 1'b1;
                r_pat     <= pattern_sel;
                r_solid   <= solid_rgb565;
                r_y       <= '0;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_vline <= r_vline + 6'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // High byte goes out now, low byte is held for the following cycle.
      if (w_emit_hi) begin
        CAM_px_data <= w_pixel[15:8];
        r_lo_byte   <= w_pixel[7:0];
        r_px_x      <= r_px_x + 8'd1;
        if (r_bar_pos == BAR_LAST) begin
          r_bar_pos <= '0;
          r_bar     <= r_bar + 3'd1;
        end else begin
          r_bar_pos <= r_bar_pos + 7'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/cam_stream_gen.md
Name: cam_stream_gen

Overview:
- Synthesizable camera-side transmitter: generates an OV7670-style pixel stream (CAM_VSYNC, CAM_HREF, CAM_px_data, two bytes per RGB565 pixel) from an internal test-pattern source.
- Drives the capture path directly on the bench and on the board, so the RAM write path can run without a physical sensor.
- Runs on the pixel clock; the capture block samples the same clock.

Parameters:
- H_ACTIVE, 160, pixels per line (even, multiple of 8)
- V_ACTIVE, 120, active lines per frame
- H_BLANK, 144, PCLK cycles with HREF low after each line (>=1)
- VSYNC_LEN, 3, lines with VSYNC high
- V_BACK, 17, blank lines between VSYNC fall and first HREF
- V_FRONT, 10, blank lines after last active line

Ports:
- CAM_PCLK  in  1  pixel clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  1 = stream frames continuously
- pattern_sel  in  2  0 colour bars, 1 ramp, 2 solid, 3 checker
- solid_rgb565  in  16  colour for pattern 2
- CAM_VSYNC  out  1  frame sync, active high
- CAM_HREF  out  1  line valid, active high
- CAM_px_data  out  8  pixel byte
- frame_done  out  1  one-cycle pulse at end of each frame's V_FRONT
- frame_cnt  out  16  completed frames, wraps at 0xFFFF->0

Behaviour:
- LINE_LEN = 2*H_ACTIVE + H_BLANK cycles. All outputs are registered.
- rst=0 (async): state IDLE, all counters 0, CAM_VSYNC=0, CAM_HREF=0, CAM_px_data=0, frame_done=0, frame_cnt=0. Mid-frame reset aborts immediately. After release, streaming starts only when enable is sampled.
- States:
  - IDLE: outputs low. enable=1 at an edge -> VSYNC; CAM_VSYNC=1 from that edge. pattern_sel and solid_rgb565 are latched here and held for the whole frame.
  - VSYNC: CAM_VSYNC=1 for VSYNC_LEN*LINE_LEN cycles -> VBACK.
  - VBACK: all low for V_BACK*LINE_LEN cycles -> ACTIVE (line y=0).
  - ACTIVE: CAM_HREF=1 for exactly 2*H_ACTIVE cycles; byte index b=0..2*H_ACTIVE-1, pixel x=b>>1.
    - Even b: CAM_px_data = pixel[15:8].
    - Odd b: CAM_px_data = pixel[7:0].
    - Then -> HBLANK.
  - HBLANK: HREF low, data 0, for H_BLANK cycles. Then y++ -> ACTIVE if y<V_ACTIVE, else -> VFRONT.
  - VFRONT: low for V_FRONT*LINE_LEN cycles.
    - On the last cycle: frame_done=1 for one cycle and frame_cnt++.
    - If enable=1: -> VSYNC, re-latching pattern inputs.
    - Else: -> IDLE.
- enable deassertion mid-frame never truncates a frame; it is only checked in IDLE and at the end of VFRONT.
- CAM_px_data is 0 whenever CAM_HREF=0.
- Patterns (pixel = RGB565 {R5,G6,B5}):
  - 0 colour bars: 8 bars of width H_ACTIVE/8, in order white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
  - 1 ramp: R=x[7:3], G=x[7:2], B=x[7:3] (x truncated to 8 bits).
  - 2 solid: latched solid_rgb565.
  - 3 checker: (x[3]^y[3]) ? FFFF : 0000.
- Counters are sized for default parameters plus margin:
  - byte counter: 10 bits
  - line counter: 9 bits
  - cycle-in-line counter: 10 bits
  - blank-line counter: 6 bits
- Counters must not overflow for any legal parameter set with 2*H_ACTIVE+H_BLANK <= 1023.

Test Plan:
- Small parameters H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VSYNC_LEN=1, V_BACK=1, V_FRONT=1 (LINE_LEN=20); enable=1 after reset:
  - VSYNC high exactly 20 cycles, then 20 low cycles.
  - Then 4 HREF pulses of 16 cycles, each separated by 4 low cycles.
  - frame_done pulses once, 140 cycles after VSYNC rose; frame_cnt=1.
- pattern_sel=2, solid_rgb565=0xA5C3 -> bytes inside HREF alternate A5,C3; 0x00 outside HREF.
- pattern_sel=0 with default parameters:
  - line 0 bytes 0-1 = FF,FF.
  - bytes 40-41 (x=20) = FF,E0.
  - bytes 318-319 (x=159) = 00,00.
- enable dropped halfway through ACTIVE:
  - the frame completes, frame_done pulses, state returns to IDLE.
  - No further VSYNC until enable=1 again.
- rst pulsed low mid-HREF, asynchronous to the clock edge:
  - HREF and data go to 0 immediately; frame_cnt=0.
  - After release with enable=1, a fresh VSYNC starts on the first edge.
- Back-to-back frames with pattern_sel changed mid-frame:
  - the current frame keeps the old pattern; the next frame uses the new one.
  - frame_cnt increments by exactly 1 per frame.
